dram_device_model: RTL
======================

# dram_device_model

Cycle-accurate, single-bank DRAM device behind the DRAM pin interface driven by the DRAM controller wrapper: decodes CSn/RASn/CASn/WEn commands, keeps one open row, and returns read data on DRAM_Q with a fixed CAS latency and a one-cycle DRAM_valid pulse. It sits at the top-level testbench/SoC boundary as the memory the wrapper talks to, and flags protocol violations for verification.

## Interface
- ROW_BITS, 11, row address width (row taken from DRAM_A[ROW_BITS-1:0])
- COL_BITS, 10, column address width (column taken from DRAM_A[COL_BITS-1:0])
- T_RCD, 5, minimum cycles from ACT to first CAS
- T_RP, 5, minimum cycles from PRE to next ACT
- CL, 5, cycles from read CAS to DRAM_valid
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- DRAM_CSn  in  1  chip select, active low; commands decoded only when 0
- DRAM_RASn  in  1  row strobe, active low
- DRAM_CASn  in  1  column strobe, active low
- DRAM_WEn  in  4  per-byte write enable, active low (bit i = byte i)
- DRAM_A  in  11  multiplexed row/column address
- DRAM_D  in  32  write data
- DRAM_valid  out  1  read data valid, one-cycle pulse
- DRAM_Q  out  32  read data, held between pulses
- illegal_cmd  out  1  one-cycle pulse: previous edge carried an illegal command

## Operation
- Array: 2^(ROW_BITS+COL_BITS) × 32-bit words, index {row, col}; not cleared by reset.
- Commands sampled at rising clk when CSn=0 (CSn=1 → NOP):
  - ACT: RASn=0, CASn=1, WEn=4'hf → open row DRAM_A.
  - PRE: RASn=0, CASn=1, WEn=4'h0 → close row.
  - RD: RASn=1, CASn=0, WEn=4'hf → read {open_row, col}.
  - WR: RASn=1, CASn=0, WEn≠4'hf → write bytes with WEn[i]=0 from DRAM_D.
  - RASn=0 and CASn=0 together, or RASn=0 with WEn not 4'hf/4'h0 → illegal.
- Bank FSM:
  - CLOSED → (ACT) → ACTIVATING; counter runs T_RCD-1 cycles → OPEN.
  - OPEN: RD/WR accepted; PRE → PRECHARGING; counter runs T_RP-1 cycles → CLOSED.
  - Illegal (ignored, state unchanged, illegal_cmd pulse): ACT outside CLOSED; RD/WR outside OPEN; PRE in CLOSED/ACTIVATING/PRECHARGING; RD while a read is pending.
- Read path: word is read from the array at the RD edge into a pending slot with a down-counter; later writes do not affect it. A PRE issued while a read is pending does not cancel it.
- Writes take effect at the WR edge; a RD on the next edge returns the new data.

## Timing
- Reset (rst=0, async): DRAM_valid=0, DRAM_Q=32'h0, illegal_cmd=0, FSM=CLOSED, counters=0, pending read cancelled. Mid-operation reset discards any in-flight read; no valid is produced for it.
- ACT at edge t: earliest legal RD/WR at edge t+T_RCD; at t+T_RCD-1 → illegal.
- PRE at edge p: earliest legal ACT at edge p+T_RP.
- RD at edge c: DRAM_valid=1 and DRAM_Q=data during cycle following edge c+CL-1 (i.e. sampled high by the controller at edge c+CL); DRAM_valid back to 0 next cycle; DRAM_Q keeps the value.
- Next RD legal at the edge at or after the one where DRAM_valid is driven high.
- illegal_cmd asserts the cycle after the offending edge, for one cycle; consecutive illegal edges give consecutive pulses.
- Address arithmetic: no wrap or carry between col and row; DRAM_A bits above COL_BITS ignored for RD/WR.

## Test plan
- Reset, ACT row 0x005 at edge 0, WR col 0x010 D=32'hDEADBEEF WEn=4'h0 at edge 5, RD col 0x010 at edge 6 -> DRAM_valid single pulse, sampled at edge 11, DRAM_Q=32'hDEADBEEF, held after.
- Byte writes: full write 32'h11223344, then WEn=4'b1010 D=32'hAABBCCDD -> read returns 32'h11BB33DD.
- Timing violations: RD at ACT+4 -> illegal_cmd pulse, no valid; ACT at PRE+4 -> illegal_cmd, row not opened; same at +5 -> accepted.
- Row isolation: write row 1/col 3 = 32'h1, PRE, ACT row 2, write col 3 = 32'h2, PRE, ACT row 1, RD col 3 -> 32'h1.
- Pending read: RD then WR same address next edge with new data, then PRE -> valid returns old data; second RD before valid -> illegal_cmd.
- Async reset asserted 2 cycles after RD -> DRAM_valid stays 0, DRAM_Q=0, FSM CLOSED (RD after reset without ACT -> illegal_cmd); array contents survive and reread after ACT.

Source files
------------

// File: rtl/dram_device_model_if.sv
// DRAM pin bundle between the controller wrapper (master) and the device (slave).
// Handshake: commands are unconditionally sampled by the device on every rising
// clk edge; there is no ready/backpressure. DRAM_valid is a one-cycle pulse
// marking DRAM_Q as new read data; DRAM_Q holds its value between pulses.
interface dram_device_model_if;
   logic        DRAM_CSn;
   logic        DRAM_RASn;
   logic        DRAM_CASn;
   logic [3:0]  DRAM_WEn;
   logic [10:0] DRAM_A;
   logic [31:0] DRAM_D;
   logic        DRAM_valid;
   logic [31:0] DRAM_Q;
   logic        illegal_cmd;

   modport master (
      output DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
      input  DRAM_valid, DRAM_Q, illegal_cmd
   );

   modport slave (
      input  DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D,
      output DRAM_valid, DRAM_Q, illegal_cmd
   );
endinterface

// File: rtl/dram_device_model.sv
// Single-bank DRAM device model: command decode, one open row, tRCD/tRP
// timing, fixed CAS-latency read pipeline and protocol-violation flagging.
// bank_state exposes the bank FSM encoding for observation.
module dram_device_model #(
   parameter int ROW_BITS = 11,
   parameter int COL_BITS = 10,
   parameter int T_RCD    = 5,
   parameter int T_RP     = 5,
   parameter int CL       = 5
) (
   input  logic                clk,
   input  logic                rst,
   dram_device_model_if.slave  dram,
   output logic [1:0]          bank_state
);

   localparam int AW = ROW_BITS + COL_BITS;

   typedef enum logic [1:0] {
      ST_CLOSED      = 2'd0,
      ST_ACTIVATING  = 2'd1,
      ST_OPEN        = 2'd2,
      ST_PRECHARGING = 2'd3
   } bank_state_t;

   bank_state_t         state;
   logic [7:0]          bank_cnt;
   logic [ROW_BITS-1:0] open_row;
   logic                rd_pending;
   logic [7:0]          rd_cnt;
   logic [31:0]         rd_word;

   // Storage is deliberately never reset: contents survive rst.
   logic [31:0] mem [0:(1<<AW)-1];

   logic [ROW_BITS-1:0] cmd_row;
   logic [COL_BITS-1:0] cmd_col;
   logic [AW-1:0]       acc_addr;
   logic [31:0]         rd_now;

   logic is_act, is_pre, is_rd, is_wr, bad_enc;
   logic act_ok, pre_ok, rd_ok, wr_ok, rd_busy, illegal_now;

   assign cmd_row  = dram.DRAM_A[ROW_BITS-1:0];
   assign cmd_col  = dram.DRAM_A[COL_BITS-1:0];
   assign acc_addr = {open_row, cmd_col};
   assign rd_now   = mem[acc_addr];

   // Decode the pin encoding into one command class (or a bad encoding).
   always_comb begin
      is_act  = 1'b0;
      is_pre  = 1'b0;
      is_rd   = 1'b0;
      is_wr   = 1'b0;
      bad_enc = 1'b0;
      if (!dram.DRAM_CSn) begin
         if (!dram.DRAM_RASn && !dram.DRAM_CASn) begin
            bad_enc = 1'b1;
         end else if (!dram.DRAM_RASn) begin
            if (dram.DRAM_WEn == 4'hf)      is_act  = 1'b1;
            else if (dram.DRAM_WEn == 4'h0) is_pre  = 1'b1;
            else                            bad_enc = 1'b1;
         end else if (!dram.DRAM_CASn) begin
            if (dram.DRAM_WEn == 4'hf) is_rd = 1'b1;
            else                       is_wr = 1'b1;
         end
      end
   end

   // A pending read stops blocking a new RD on the edge that fires its valid.
   assign rd_busy = rd_pending && (rd_cnt != 8'd1);

   // Legality of each command against the current bank state.
   always_comb begin
      act_ok      = is_act && (state == ST_CLOSED);
      pre_ok      = is_pre && (state == ST_OPEN);
      wr_ok       = is_wr  && (state == ST_OPEN);
      rd_ok       = is_rd  && (state == ST_OPEN) && !rd_busy;
      illegal_now = bad_enc || (is_act && !act_ok) || (is_pre && !pre_ok) ||
                    (is_wr && !wr_ok) || (is_rd && !rd_ok);
   end

   assign bank_state = state;

   // Array write with per-byte enables (active-low WEn).
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (!dram.DRAM_WEn[i]) mem[acc_addr][8*i +: 8] <= dram.DRAM_D[8*i +: 8];
         end
      end
   end

   // Bank FSM, timing counters, read pipeline and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_CLOSED;
         bank_cnt         <= 8'd0;
         open_row         <= '0;
         rd_pending       <= 1'b0;
         rd_cnt           <= 8'd0;
         rd_word          <= 32'h0;
         dram.DRAM_valid  <= 1'b0;
         dram.DRAM_Q      <= 32'h0;
         dram.illegal_cmd <= 1'b0;
      end else begin
         dram.illegal_cmd <= illegal_now;
         dram.DRAM_valid  <= 1'b0;

         case (state)
            ST_CLOSED: begin
               if (act_ok) begin
                  open_row <= cmd_row;
                  if (T_RCD <= 1) begin
                     state <= ST_OPEN;
                  end else begin
                     state    <= ST_ACTIVATING;
                     bank_cnt <= 8'(T_RCD - 1);
                  end
               end
            end
            ST_ACTIVATING: begin
               if (bank_cnt <= 8'd1) begin
                  state    <= ST_OPEN;
                  bank_cnt <= 8'd0;
               end else begin
                  bank_cnt <= bank_cnt - 8'd1;
               end
            end
            ST_OPEN: begin
               if (pre_ok) begin
                  if (T_RP <= 1) begin
                     state <= ST_CLOSED;
                  end else begin
                     state    <= ST_PRECHARGING;
                     bank_cnt <= 8'(T_RP - 1);
                  end
               end
            end
            ST_PRECHARGING: begin
               if (bank_cnt <= 8'd1) begin
                  state    <= ST_CLOSED;
                  bank_cnt <= 8'd0;
               end else begin
                  bank_cnt <= bank_cnt - 8'd1;
               end
            end
            default: state <= ST_CLOSED;
         endcase

         // Pending read: data was captured at the RD edge, so later writes
         // and a PRE do not disturb it.
         if (rd_pending) begin
            if (rd_cnt == 8'd1) begin
               dram.DRAM_valid <= 1'b1;
               dram.DRAM_Q     <= rd_word;
               rd_pending      <= 1'b0;
               rd_cnt          <= 8'd0;
            end else begin
               rd_cnt <= rd_cnt - 8'd1;
            end
         end

         // A new RD may be accepted on the same edge the previous one fires.
         if (rd_ok) begin
            if (CL <= 1) begin
               dram.DRAM_valid <= 1'b1;
               dram.DRAM_Q     <= rd_now;
            end else begin
               rd_pending <= 1'b1;
               rd_cnt     <= 8'(CL - 1);
               rd_word    <= rd_now;
            end
         end
      end
   end

endmodule
